// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/forwarding controller for the 5-stage pipeline
// Optional macro BRANCH_PREDICT_NT_EN: predict not-taken with flush instead of branch-pending stall.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_DEPTH    = 3,
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_STAGE = 2,
    localparam int SEL_W       = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic                  id_rs_used,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rt_used,
    input  logic                  id_wen,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  id_is_load,
    input  logic                  id_is_branch,
    input  logic                  br_resolve_valid,
    input  logic                  br_taken,
    output logic                  if_en,
    output logic                  id_en,
    output logic                  id_rst,
    output logic                  exe_rst,
    output logic                  mem_rst,
    output logic [SEL_W-1:0]      exe_fwd_a_ctrl,
    output logic [SEL_W-1:0]      exe_fwd_b_ctrl,
    output logic [31:0]           stall_cnt
);

    // Entry k describes the instruction currently in stage EXE+k.
    logic [FWD_DEPTH-1:0]  sb_v;
    logic [FWD_DEPTH-1:0]  sb_ld;
    logic [REG_ADDR_W-1:0] sb_waddr [FWD_DEPTH];

    logic             rs_hit, rt_hit, rs_ld, rt_ld;
    logic [SEL_W-1:0] rs_idx, rt_idx;
    logic             ld_stall, flush, br_wait, advance;

    always_comb begin
        rs_hit = 1'b0;
        rs_idx = '0;
        rs_ld  = 1'b0;
        rt_hit = 1'b0;
        rt_idx = '0;
        rt_ld  = 1'b0;
        // Scan oldest to youngest so the youngest matching writer is left standing.
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (id_rs_used && id_rs_addr != '0 && sb_v[k] && sb_waddr[k] == id_rs_addr) begin
                rs_hit = 1'b1;
                rs_idx = SEL_W'(k);
                rs_ld  = sb_ld[k];
            end
            if (id_rt_used && id_rt_addr != '0 && sb_v[k] && sb_waddr[k] == id_rt_addr) begin
                rt_hit = 1'b1;
                rt_idx = SEL_W'(k);
                rt_ld  = sb_ld[k];
            end
        end
    end

    assign ld_stall = id_valid &
                      ((rs_hit & rs_ld & (rs_idx < SEL_W'(LOAD_LAT))) |
                       (rt_hit & rt_ld & (rt_idx < SEL_W'(LOAD_LAT))));

`ifdef BRANCH_PREDICT_NT_EN
    logic unused_id_is_branch;
    assign unused_id_is_branch = id_is_branch;
    assign flush   = br_resolve_valid & br_taken;
    assign br_wait = 1'b0;
`else
    logic br_pending;
    logic unused_br_taken;
    assign unused_br_taken = br_taken;
    assign flush   = 1'b0;
    assign br_wait = br_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_pending <= 1'b0;
        end else if (br_pending) begin
            br_pending <= !br_resolve_valid;
        end else begin
            br_pending <= id_valid & id_is_branch & advance;
        end
    end
`endif

    assign advance = !ld_stall && !flush;

    always_comb begin
        if_en   = 1'b1;
        id_en   = 1'b1;
        id_rst  = 1'b0;
        exe_rst = 1'b0;
        mem_rst = 1'b0;
        if (!rst_n) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
        end else if (flush) begin
            id_en   = 1'b0;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = (BRANCH_STAGE == 2);
        end else if (ld_stall) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else if (br_wait) begin
            // Only the resolve cycle lets IF fetch the (possibly redirected) PC.
            if_en  = br_resolve_valid;
            id_en  = 1'b0;
            id_rst = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v  <= '0;
            sb_ld <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb_waddr[k] <= '0;
            end
        end else begin
            sb_v[0]     <= id_valid & id_wen & (id_waddr != '0) & advance;
            sb_ld[0]    <= id_is_load;
            sb_waddr[0] <= id_waddr;
            // A taken flush kills the wrong-path instructions sitting ahead of the resolve stage.
            for (int k = 1; k < FWD_DEPTH; k++) begin
                sb_v[k]     <= sb_v[k-1] & ~(flush & (k < BRANCH_STAGE));
                sb_ld[k]    <= sb_ld[k-1];
                sb_waddr[k] <= sb_waddr[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_fwd_a_ctrl <= '0;
            exe_fwd_b_ctrl <= '0;
        end else begin
            exe_fwd_a_ctrl <= (advance && id_valid && rs_hit) ? rs_idx + SEL_W'(1) : '0;
            exe_fwd_b_ctrl <= (advance && id_valid && rt_hit) ? rt_idx + SEL_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((ld_stall || br_wait) && !flush && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
